// File: rtl/fault_schedule_ctrl.sv
// fault_schedule_ctrl: programmable fault-injection scheduler.
// Holds NUM_SLOTS (cycle, mask) entries. Once armed, it opens a window on the
// next rising edge of trig. Each enabled slot then drives its XOR mask for
// exactly one cycle, when the window cycle counter equals the slot cycle.
// Optional feature macro FAULT_SCHED_GLITCH_EN adds a per-slot glitch bit, the
// cfg_glitch input and the glitch_req output.
module fault_schedule_ctrl #(
    parameter int NUM_SLOTS = 4,
    parameter int MASK_W    = 8,
    parameter int CNT_W     = 16,
    localparam int ADDR_W   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
    localparam int HIT_W    = $clog2(NUM_SLOTS + 1)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              trig,
    input  logic              arm,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic              cfg_en,
    input  logic [CNT_W-1:0]  cfg_cycle,
    input  logic [MASK_W-1:0] cfg_mask,
`ifdef FAULT_SCHED_GLITCH_EN
    input  logic              cfg_glitch,
    output logic              glitch_req,
`endif
    output logic              cfg_err,
    output logic [MASK_W-1:0] fault_mask,
    output logic              fault_valid,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic              busy,
    output logic              done,
    output logic [HIT_W-1:0]  hit_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_WINDOW} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t              state_reg;
    logic                trig_q_reg;
    logic                rise_q_reg;
    logic [CNT_W-1:0]    cycle_cnt_reg;
    logic [HIT_W-1:0]    hit_cnt_reg;
    logic [MASK_W-1:0]   fault_mask_reg;
    logic                fault_valid_reg;
    logic                done_reg;
    logic                cfg_err_reg;

    logic                wr_ok;
    logic                enter_win;
    logic                stay_win;
    logic [CNT_W-1:0]    cnt_next;
    logic [NUM_SLOTS-1:0] fire;
    logic [MASK_W-1:0]   mask_next;
    logic [HIT_W-1:0]    fire_cnt;

    logic                slot_en_reg    [NUM_SLOTS];
    logic                slot_fired_reg [NUM_SLOTS];
    logic [CNT_W-1:0]    slot_cycle_reg [NUM_SLOTS];
    logic [MASK_W-1:0]   slot_mask_reg  [NUM_SLOTS];

`ifdef FAULT_SCHED_GLITCH_EN
    logic                 slot_glitch_reg [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] glitch_fire;
    logic                 glitch_req_reg;
    assign glitch_req = glitch_req_reg;
`endif

    // The table only accepts writes while idle, so a running window never
    // sees its schedule change underneath it.
    assign wr_ok     = cfg_we && (state_reg == S_IDLE);
    // rise_q is the registered rise detect, so cycle 0 starts two edges after trig rises.
    assign enter_win = (state_reg == S_ARMED) && rise_q_reg;
    assign stay_win  = (state_reg == S_WINDOW) && trig_q_reg;

    // Next counter value; the masks are matched against this so the registered
    // outputs line up with the cycle_cnt value they belong to.
    always_comb begin
        cnt_next = cycle_cnt_reg;
        if (enter_win) begin
            cnt_next = '0;
        end else if (cycle_cnt_reg != CNT_MAX) begin
            cnt_next = cycle_cnt_reg + CNT_W'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            // Stale fired flags from the previous window are ignored on window entry.
            assign fire[gi] = (enter_win || stay_win) && slot_en_reg[gi] &&
                              (enter_win || !slot_fired_reg[gi]) &&
                              (slot_cycle_reg[gi] == cnt_next);

            // Slot storage: written in one cycle while idle, cleared by reset.
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    slot_en_reg[gi]    <= 1'b0;
                    slot_cycle_reg[gi] <= '0;
                    slot_mask_reg[gi]  <= '0;
                end else if (wr_ok && (cfg_addr == ADDR_W'(gi))) begin
                    slot_en_reg[gi]    <= cfg_en;
                    slot_cycle_reg[gi] <= cfg_cycle;
                    slot_mask_reg[gi]  <= cfg_mask;
                end
            end

            // One-shot flag so a saturated counter cannot fire a slot twice.
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    slot_fired_reg[gi] <= 1'b0;
                end else if (enter_win) begin
                    slot_fired_reg[gi] <= fire[gi];
                end else if (fire[gi]) begin
                    slot_fired_reg[gi] <= 1'b1;
                end
            end

`ifdef FAULT_SCHED_GLITCH_EN
            assign glitch_fire[gi] = fire[gi] && slot_glitch_reg[gi];

            // Glitch bit is stored alongside the rest of the entry.
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    slot_glitch_reg[gi] <= 1'b0;
                end else if (wr_ok && (cfg_addr == ADDR_W'(gi))) begin
                    slot_glitch_reg[gi] <= cfg_glitch;
                end
            end
`endif
        end
    endgenerate

    // Combine all slots firing this cycle: OR of masks and count of hits.
    always_comb begin
        mask_next = '0;
        fire_cnt  = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (fire[i]) begin
                mask_next = mask_next | slot_mask_reg[i];
            end
            fire_cnt = fire_cnt + HIT_W'(fire[i]);
        end
    end

    // Scheduler FSM with registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg       <= S_IDLE;
            trig_q_reg      <= 1'b0;
            rise_q_reg      <= 1'b0;
            cycle_cnt_reg   <= '0;
            hit_cnt_reg     <= '0;
            fault_mask_reg  <= '0;
            fault_valid_reg <= 1'b0;
            done_reg        <= 1'b0;
            cfg_err_reg     <= 1'b0;
`ifdef FAULT_SCHED_GLITCH_EN
            glitch_req_reg  <= 1'b0;
`endif
        end else begin
            trig_q_reg      <= trig;
            rise_q_reg      <= (state_reg == S_ARMED) && trig && !trig_q_reg;
            cfg_err_reg     <= cfg_we && (state_reg != S_IDLE);
            done_reg        <= 1'b0;
            // fire is already gated by the window, so these are zero outside it
            // and in the closing cycle.
            fault_mask_reg  <= mask_next;
            fault_valid_reg <= |mask_next;
`ifdef FAULT_SCHED_GLITCH_EN
            glitch_req_reg  <= |glitch_fire;
`endif
            case (state_reg)
                S_IDLE: begin
                    if (arm) begin
                        hit_cnt_reg <= '0;
                        state_reg   <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (enter_win) begin
                        cycle_cnt_reg <= cnt_next;
                        hit_cnt_reg   <= hit_cnt_reg + fire_cnt;
                        state_reg     <= S_WINDOW;
                    end
                end
                S_WINDOW: begin
                    if (trig_q_reg) begin
                        cycle_cnt_reg <= cnt_next;
                        hit_cnt_reg   <= hit_cnt_reg + fire_cnt;
                    end else begin
                        done_reg  <= 1'b1;
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign cfg_err     = cfg_err_reg;
    assign fault_mask  = fault_mask_reg;
    assign fault_valid = fault_valid_reg;
    assign cycle_cnt   = cycle_cnt_reg;
    assign busy        = (state_reg != S_IDLE);
    assign done        = done_reg;
    assign hit_cnt     = hit_cnt_reg;

endmodule

// File: tb/tb_fault_schedule_ctrl.sv
// Directed testbench for fault_schedule_ctrl (default parameters).
// Build with FAULT_SCHED_GLITCH_EN defined to also exercise glitch_req.
module tb_fault_schedule_ctrl;

    localparam int NUM_SLOTS = 4;
    localparam int MASK_W    = 8;
    localparam int CNT_W     = 16;
    localparam int ADDR_W    = 2;
    localparam int HIT_W     = 3;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              trig = 1'b0;
    logic              arm = 1'b0;
    logic              cfg_we = 1'b0;
    logic [ADDR_W-1:0] cfg_addr = '0;
    logic              cfg_en = 1'b0;
    logic [CNT_W-1:0]  cfg_cycle = '0;
    logic [MASK_W-1:0] cfg_mask = '0;
    logic              cfg_glitch = 1'b0;
    logic              glitch_obs;
    logic              cfg_err;
    logic [MASK_W-1:0] fault_mask;
    logic              fault_valid;
    logic [CNT_W-1:0]  cycle_cnt;
    logic              busy;
    logic              done;
    logic [HIT_W-1:0]  hit_cnt;

    int errors = 0;
    int checks = 0;

    // Observations gathered by run_window, compared by the calling test.
    int rw_mask_errs;
    int rw_cnt_errs;
    int rw_valid_errs;
    int rw_busy_errs;
    int rw_glitch_errs;
    int rw_done_cnt;
    int rw_done_tick;

    always #5 clk = ~clk;

    fault_schedule_ctrl #(
        .NUM_SLOTS (NUM_SLOTS),
        .MASK_W    (MASK_W),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .trig        (trig),
        .arm         (arm),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_en      (cfg_en),
        .cfg_cycle   (cfg_cycle),
        .cfg_mask    (cfg_mask),
`ifdef FAULT_SCHED_GLITCH_EN
        .cfg_glitch  (cfg_glitch),
        .glitch_req  (glitch_obs),
`endif
        .cfg_err     (cfg_err),
        .fault_mask  (fault_mask),
        .fault_valid (fault_valid),
        .cycle_cnt   (cycle_cnt),
        .busy        (busy),
        .done        (done),
        .hit_cnt     (hit_cnt)
    );

`ifndef FAULT_SCHED_GLITCH_EN
    assign glitch_obs = 1'b0;
`endif

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_slot(input int addr, input logic en, input int cyc,
                              input int mask, input logic glitch);
        cfg_we     = 1'b1;
        cfg_addr   = ADDR_W'(addr);
        cfg_en     = en;
        cfg_cycle  = CNT_W'(cyc);
        cfg_mask   = MASK_W'(mask);
        cfg_glitch = glitch;
        tick();
        cfg_we     = 1'b0;
        cfg_glitch = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    // Holds trig high for 'hold' cycles (window cycles 0..hold-1) and tallies
    // deviations from the expected per-cycle outputs. Assumes the block is armed.
    task automatic run_window(input int hold, input int c0, input int m0,
                              input int c1, input int m1, input int gc);
        int wc;
        logic [MASK_W-1:0] exp_mask;
        logic exp_glitch;
        rw_mask_errs = 0; rw_cnt_errs = 0; rw_valid_errs = 0;
        rw_busy_errs = 0; rw_glitch_errs = 0; rw_done_cnt = 0; rw_done_tick = -1;
        trig = 1'b1;
        for (int n = 1; n <= hold + 4; n++) begin
            tick();
            wc = n - 2;
            exp_mask = '0;
            exp_glitch = 1'b0;
            if (n >= 2 && n <= hold + 1) begin
                if (wc == c0) exp_mask = exp_mask | MASK_W'(m0);
                if (wc == c1) exp_mask = exp_mask | MASK_W'(m1);
                if (wc == gc) exp_glitch = 1'b1;
                if (cycle_cnt !== CNT_W'(wc)) rw_cnt_errs++;
            end
            if (fault_mask !== exp_mask) rw_mask_errs++;
            if (fault_valid !== (exp_mask != '0)) rw_valid_errs++;
            if (glitch_obs !== exp_glitch) rw_glitch_errs++;
            if (busy !== (n <= hold + 1)) rw_busy_errs++;
            if (done === 1'b1) begin
                rw_done_cnt++;
                rw_done_tick = n;
            end
            if (n == hold) trig = 1'b0;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick(); tick();
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err got=%0b want=0", cfg_err); end
        checks++; if (fault_mask !== 8'h00) begin errors++; $display("FAIL reset_fault_mask got=%h want=00", fault_mask); end
        checks++; if (fault_valid !== 1'b0) begin errors++; $display("FAIL reset_fault_valid got=%0b want=0", fault_valid); end
        checks++; if (cycle_cnt !== 16'd0) begin errors++; $display("FAIL reset_cycle_cnt got=%0d want=0", cycle_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b want=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b want=0", done); end
        checks++; if (hit_cnt !== 3'd0) begin errors++; $display("FAIL reset_hit_cnt got=%0d want=0", hit_cnt); end
        resetn = 1'b1;
        tick();
        $display("test_reset: outputs after reset mask=%h cnt=%0d busy=%0b", fault_mask, cycle_cnt, busy);
    endtask

    task automatic test_two_slots();
        write_slot(0, 1'b1, 613, 8'h07, 1'b0);
        write_slot(1, 1'b1, 1256, 8'h07, 1'b0);
        do_arm();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL two_slots_armed_busy got=%0b want=1", busy); end
        run_window(2000, 613, 8'h07, 1256, 8'h07, -1);
        checks++; if (rw_mask_errs !== 0) begin errors++; $display("FAIL two_slots_mask bad_cycles=%0d want=0", rw_mask_errs); end
        checks++; if (rw_cnt_errs !== 0) begin errors++; $display("FAIL two_slots_cycle_cnt bad_cycles=%0d want=0", rw_cnt_errs); end
        checks++; if (rw_valid_errs !== 0) begin errors++; $display("FAIL two_slots_valid bad_cycles=%0d want=0", rw_valid_errs); end
        checks++; if (rw_busy_errs !== 0) begin errors++; $display("FAIL two_slots_busy bad_cycles=%0d want=0", rw_busy_errs); end
        checks++; if (rw_done_cnt !== 1 || rw_done_tick !== 2002) begin errors++; $display("FAIL two_slots_done pulses=%0d at=%0d want=1 at 2002", rw_done_cnt, rw_done_tick); end
        checks++; if (hit_cnt !== 3'd2) begin errors++; $display("FAIL two_slots_hit_cnt got=%0d want=2", hit_cnt); end
        $display("test_two_slots: hit_cnt=%0d done_pulses=%0d", hit_cnt, rw_done_cnt);
    endtask

    task automatic test_duplicate();
        write_slot(0, 1'b1, 10, 8'h01, 1'b0);
        // Write slot1 in the same cycle as arm: the entry must take part in the window.
        cfg_we = 1'b1; cfg_addr = 2'd1; cfg_en = 1'b1; cfg_cycle = 16'd10; cfg_mask = 8'h80;
        arm = 1'b1;
        tick();
        cfg_we = 1'b0; arm = 1'b0;
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL dup_arm_write_err got=%0b want=0", cfg_err); end
        checks++; if (hit_cnt !== 3'd0) begin errors++; $display("FAIL dup_arm_clears_hit got=%0d want=0", hit_cnt); end
        run_window(40, 10, 8'h01, 10, 8'h80, -1);
        checks++; if (rw_mask_errs !== 0) begin errors++; $display("FAIL dup_mask bad_cycles=%0d want=0", rw_mask_errs); end
        checks++; if (hit_cnt !== 3'd2) begin errors++; $display("FAIL dup_hit_cnt got=%0d want=2", hit_cnt); end
        $display("test_duplicate: hit_cnt=%0d", hit_cnt);
    endtask

    task automatic test_early_fall();
        write_slot(1, 1'b0, 0, 8'h00, 1'b0);
        write_slot(0, 1'b1, 50, 8'hFF, 1'b0);
        do_arm();
        run_window(31, 50, 8'hFF, -1, 0, -1);
        checks++; if (rw_mask_errs !== 0) begin errors++; $display("FAIL early_mask bad_cycles=%0d want=0", rw_mask_errs); end
        checks++; if (rw_done_cnt !== 1 || rw_done_tick !== 33) begin errors++; $display("FAIL early_done pulses=%0d at=%0d want=1 at 33", rw_done_cnt, rw_done_tick); end
        checks++; if (hit_cnt !== 3'd0) begin errors++; $display("FAIL early_hit_cnt got=%0d want=0", hit_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL early_idle busy=%0b want=0", busy); end
        $display("test_early_fall: last cycle_cnt=%0d done_at=%0d", cycle_cnt, rw_done_tick);
    endtask

    task automatic test_cfg_busy();
        write_slot(0, 1'b1, 20, 8'h3C, 1'b0);
        do_arm();
        trig = 1'b1;
        tick(); tick(); tick();
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_en = 1'b1; cfg_cycle = 16'd5; cfg_mask = 8'hFF;
        tick();
        cfg_we = 1'b0;
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_pulse got=%0b want=1", cfg_err); end
        tick();
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_one_cycle got=%0b want=0", cfg_err); end
        trig = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cfg_busy_closed busy=%0b want=0", busy); end
        do_arm();
        run_window(40, 20, 8'h3C, -1, 0, -1);
        checks++; if (rw_mask_errs !== 0) begin errors++; $display("FAIL cfg_busy_table bad_cycles=%0d want=0", rw_mask_errs); end
        checks++; if (hit_cnt !== 3'd1) begin errors++; $display("FAIL cfg_busy_hit_cnt got=%0d want=1", hit_cnt); end
        $display("test_cfg_busy: table kept, hit_cnt=%0d", hit_cnt);
    endtask

    task automatic test_reset_mid_window();
        write_slot(0, 1'b1, 3, 8'h3C, 1'b0);
        do_arm();
        trig = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        checks++; if (cycle_cnt !== 16'd5 || hit_cnt !== 3'd1) begin errors++; $display("FAIL midrst_pre cnt=%0d hit=%0d want 5/1", cycle_cnt, hit_cnt); end
        resetn = 1'b0;
        #1;
        checks++; if (cycle_cnt !== 16'd0 || hit_cnt !== 3'd0 || busy !== 1'b0 || fault_mask !== 8'h00) begin
            errors++; $display("FAIL midrst_async cnt=%0d hit=%0d busy=%0b mask=%h want all 0", cycle_cnt, hit_cnt, busy, fault_mask);
        end
        trig = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        do_arm();
        run_window(20, -1, 0, -1, 0, -1);
        checks++; if (rw_mask_errs !== 0) begin errors++; $display("FAIL midrst_no_fire bad_cycles=%0d want=0", rw_mask_errs); end
        checks++; if (hit_cnt !== 3'd0) begin errors++; $display("FAIL midrst_hit_cnt got=%0d want=0", hit_cnt); end
        $display("test_reset_mid_window: rearmed window hit_cnt=%0d", hit_cnt);
    endtask

`ifdef FAULT_SCHED_GLITCH_EN
    task automatic test_glitch();
        write_slot(0, 1'b1, 100, 8'h00, 1'b1);
        do_arm();
        run_window(120, 100, 8'h00, -1, 0, 100);
        checks++; if (rw_glitch_errs !== 0) begin errors++; $display("FAIL glitch_req bad_cycles=%0d want=0", rw_glitch_errs); end
        checks++; if (rw_valid_errs !== 0) begin errors++; $display("FAIL glitch_valid bad_cycles=%0d want=0", rw_valid_errs); end
        checks++; if (hit_cnt !== 3'd1) begin errors++; $display("FAIL glitch_hit_cnt got=%0d want=1", hit_cnt); end
        $display("test_glitch: hit_cnt=%0d", hit_cnt);
    endtask
`endif

    initial begin
        test_reset();
        test_two_slots();
        test_duplicate();
        test_early_fall();
        test_cfg_busy();
        test_reset_mid_window();
`ifdef FAULT_SCHED_GLITCH_EN
        test_glitch();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fault_schedule_ctrl.md
# fault_schedule_ctrl

Synthesizable, parametrised fault-injection scheduler for the picochip fault-evaluation flow. It replaces fixed, hard-coded per-cycle bit-flip schedules with a programmable table of NUM_SLOTS entries. Each entry is a (cycle, mask) pair relative to the rising edge of a GPIO trigger window. It sits beside the CPU on the chip clock and drives one-cycle XOR masks onto selected register D-inputs (the fault-injection wrapper) during the trigger window.

## Interface
Parameters:
- NUM_SLOTS, 4, number of schedule entries (1..16)
- MASK_W, 8, width of the fault mask / number of targeted flip-flops
- CNT_W, 16, width of the window cycle counter

Ports:
- clk  in  1  chip clock (the CPU clock, glitched or not)
- resetn  in  1  asynchronous, active-low reset
- trig  in  1  trigger window input (gpio[TRIGGERBIT]), already synchronous to clk
- arm  in  1  one-cycle pulse; arms the scheduler for the next window
- cfg_we  in  1  table write strobe
- cfg_addr  in  $clog2(NUM_SLOTS) (min 1)  slot index
- cfg_en  in  1  slot enable written with the entry
- cfg_cycle  in  CNT_W  target window cycle for the slot
- cfg_mask  in  MASK_W  bit-flip mask for the slot
- cfg_err  out  1  one-cycle pulse: write rejected (scheduler busy)
- fault_mask  out  MASK_W  XOR mask to apply this cycle; zero otherwise
- fault_valid  out  1  high in any cycle where fault_mask != 0 is driven
- cycle_cnt  out  CNT_W  current window cycle index
- busy  out  1  state is ARMED or WINDOW
- done  out  1  one-cycle pulse when the window closes
- hit_cnt  out  $clog2(NUM_SLOTS+1)  slots fired in the current/last window

## Operation
- States: IDLE, ARMED, WINDOW.
- IDLE: table writable. An `arm` pulse clears hit_cnt and moves to ARMED.
- ARMED: `trig_q` is trig registered. A rise (trig=1, trig_q=0) moves to WINDOW with cycle_cnt=0.
- WINDOW: cycle_cnt increments by 1 per clk and saturates at 2^CNT_W-1; it does not wrap.
  - A slot fires in the cycle where cycle_cnt == its cfg_cycle and its enable bit is set.
  - fault_mask = bitwise OR of the masks of all slots firing that cycle.
  - hit_cnt increases by the number of slots firing that cycle.
  - Each slot fires at most once per window, so saturation cannot re-fire it.
- trig low in WINDOW: return to IDLE and pulse done. The mask is forced to 0 in that cycle.
- cfg_we while busy: the write is dropped and cfg_err pulses. In IDLE the entry is written in 1 cycle.
- arm while busy: ignored.
- arm and cfg_we in the same IDLE cycle: the write lands first, and the new entry is active for the window.
- trig already high when armed: no rise is seen, so the block waits for trig to fall and rise again.
- Duplicate cfg_cycle values: masks OR together, and hit_cnt counts both slots.
- Reset, including mid-window: state IDLE, all slots disabled, tables cleared.

## Timing
- Reset values: cfg_err=0, fault_mask=0, fault_valid=0, cycle_cnt=0, busy=0, done=0, hit_cnt=0.
- Window cycle 0: the first clk edge after trig_q samples 1, i.e. 2 edges after trig rises.
- fault_mask and fault_valid are registered. They are computed from the next cycle_cnt value, so the output is valid during the cycle where cycle_cnt equals the slot cycle. There is no extra latency.
- done asserts in the cycle after trig_q falls; busy drops in the same cycle.
- cfg_err asserts the cycle after the rejected cfg_we.

## Configuration
- Macro `FAULT_SCHED_GLITCH_EN`.
- Defined:
  - Adds a per-slot glitch bit, with input `cfg_glitch` (1 bit).
  - Adds output `glitch_req` (1 bit, reset 0). It is high for exactly the fault cycle of each firing slot whose glitch bit is set. This output drives the testbench/board clock-glitch XOR.
- Undefined: neither port exists, and no glitch storage is synthesized.

## Test plan
- Slot0 = (613, 0x07), slot1 = (1256, 0x07), arm, then trig high for 2000 cycles.
  - fault_mask=0x07 exactly at cycle_cnt 613 and 1256, zero elsewhere.
  - hit_cnt=2; done pulses once.
- Slot0 = (10, 0x01), slot1 = (10, 0x80).
  - fault_mask=0x81 at cycle 10 only; hit_cnt=2.
- Slot0 at cycle 50, trig falls at cycle 30.
  - No fault output; done at fall+1; hit_cnt=0; state IDLE.
- cfg_we during WINDOW.
  - cfg_err pulses one cycle later; the table is unchanged and verified in the next window.
- resetn low at cycle 5 of the window.
  - All outputs return to 0 immediately; the slots are disabled, so the re-armed window fires nothing.
- With FAULT_SCHED_GLITCH_EN: slot (100, 0x00, glitch=1).
  - glitch_req high only at cycle 100; fault_valid stays 0.
